// File: rtl/prioq_dispatcher.sv
// prioq_dispatcher: pulls one entry from the patient priority queue and holds
// it in treatment for BASE*(pri+1) cycles, then pulses done and counts it.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   doc_avail, q_empty  start qualifiers, looked at in IDLE only
//   q_data[3:0]         queue entry {pri[1:0], id[1:0]}, valid after q_deq
//   q_deq               one-cycle registered dequeue strobe
//   busy                high from REQ through DONE
//   serv_pri, serv_id   patient in treatment (held after DONE)
//   done                one-cycle end-of-treatment pulse
//   served_cnt[7:0]     completed patients, wraps at 256
module prioq_dispatcher #(
  parameter int unsigned BASE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       doc_avail,
  input  logic       q_empty,
  input  logic [3:0] q_data,
  output logic       q_deq,
  output logic       busy,
  output logic [1:0] serv_pri,
  output logic [1:0] serv_id,
  output logic       done,
  output logic [7:0] served_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LATCH,
    S_TREAT,
    S_DONE
  } state_e;

  localparam logic [7:0] Base8 = 8'(BASE);

  state_e     state_q;
  logic       q_deq_q;
  logic       busy_q;
  logic       done_q;
  logic [1:0] pri_q;
  logic [1:0] id_q;
  logic [7:0] timer_q;
  logic [7:0] cnt_q;
  logic [7:0] load_d;

  // Treatment length for the entry on q_data; max 63*4 fits in 8 bits.
  assign load_d = Base8 * ({6'd0, q_data[3:2]} + 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_deq_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pri_q   <= 2'd0;
      id_q    <= 2'd0;
      timer_q <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (doc_avail && !q_empty) begin
            state_q <= S_REQ;
            q_deq_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_REQ: begin
          state_q <= S_LATCH;
          q_deq_q <= 1'b0;
        end
        S_LATCH: begin
          state_q <= S_TREAT;
          pri_q   <= q_data[3:2];
          id_q    <= q_data[1:0];
          timer_q <= load_d;
        end
        S_TREAT: begin
          timer_q <= timer_q - 8'd1;
          if (timer_q == 8'd1) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= cnt_q + 8'd1;
        end
        default: begin
          state_q <= S_IDLE;
          q_deq_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q_deq      = q_deq_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign serv_pri   = pri_q;
  assign serv_id    = id_q;
  assign served_cnt = cnt_q;

endmodule

// File: tb/tb_prioq_dispatcher.sv
// tb_prioq_dispatcher: directed bench for prioq_dispatcher.
// Instance a runs BASE=2, instance b runs BASE=1 for the counter wrap.
module tb_prioq_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_b = 1'b0;
  logic       doc_avail = 1'b1;
  logic       q_empty = 1'b0;
  logic [3:0] q_data = 4'd0;

  logic       q_deq_a, busy_a, done_a;
  logic [1:0] pri_a, id_a;
  logic [7:0] cnt_a;
  logic       q_deq_b, busy_b, done_b;
  logic [1:0] pri_b, id_b;
  logic [7:0] cnt_b;

  int n_chk = 0;
  int n_fail = 0;
  int deq_a = 0;
  int deq_b = 0;
  int done_a_n = 0;
  int done_b_n = 0;
  int clash = 0;
  int gap;
  int snap;
  logic [3:0] fifo[$];

  always #5 clk = ~clk;

  prioq_dispatcher #(.BASE(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .doc_avail(doc_avail), .q_empty(q_empty),
    .q_data(q_data), .q_deq(q_deq_a),
    .busy(busy_a), .serv_pri(pri_a),
    .serv_id(id_a), .done(done_a),
    .served_cnt(cnt_a)
  );

  prioq_dispatcher #(.BASE(1)) u_b (
    .clk(clk), .rst_n(rst_b),
    .doc_avail(doc_avail), .q_empty(q_empty),
    .q_data(q_data), .q_deq(q_deq_b),
    .busy(busy_b), .serv_pri(pri_b),
    .serv_id(id_b), .done(done_b),
    .served_cnt(cnt_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One cycle: sample at the falling edge, feed the queue model.
  task automatic tick;
    @(negedge clk);
    if (q_deq_a) begin
      deq_a++;
      if (fifo.size() > 0) q_data = fifo.pop_front();
    end
    if (done_a) done_a_n++;
    if (done_a && q_deq_a) clash++;
    if (q_deq_b) deq_b++;
    if (done_b) done_b_n++;
    if (done_b && q_deq_b) clash++;
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (!q_deq_a && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, int'(q_deq_a), 1);
  endtask

  // Called on the REQ cycle; follows the patient to the IDLE after DONE.
  task automatic run_patient(input string tag, input int pri,
                             input int id, input int len,
                             input bit drop);
    int bcnt;
    int doff;
    bcnt = int'(busy_a);
    doff = -1;
    for (int k = 1; k <= 300 && doff < 0; k++) begin
      tick();
      if (k == 3 && drop) doc_avail = 1'b0;
      if (busy_a) bcnt++;
      if (k == 2) begin
        chk({tag, "_pri"}, int'(pri_a), pri);
        chk({tag, "_id"}, int'(id_a), id);
      end
      if (done_a) doff = k;
    end
    chk({tag, "_done_at"}, doff, len + 2);
    tick();
    chk({tag, "_busy_cyc"}, bcnt, len + 3);
    chk({tag, "_idle"}, int'(busy_a), 0);
  endtask

  initial begin
    // Reset held with start conditions true.
    repeat (3) tick();
    chk("rst_deq", int'(q_deq_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pri", int'(pri_a), 0);
    chk("rst_id", int'(id_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_deq_n", deq_a, 0);

    // Single patient 1101.
    fifo.push_back(4'b1101);
    rst_n = 1'b1;
    tick();
    chk("rel_deq", int'(q_deq_a), 1);
    doc_avail = 1'b0;
    run_patient("p13", 3, 1, 8, 1'b0);
    chk("p13_cnt", int'(cnt_a), 1);
    chk("p13_done_n", done_a_n, 1);

    // Priority scaling: 0010 then 1011.
    fifo.push_back(4'b0010);
    fifo.push_back(4'b1011);
    doc_avail = 1'b1;
    wait_req("s0", gap);
    run_patient("s0", 0, 2, 2, 1'b0);
    wait_req("s1", gap);
    doc_avail = 1'b0;
    chk("s_gap_ok", int'(gap >= 1), 1);
    run_patient("s1", 2, 3, 6, 1'b0);
    chk("s_cnt", int'(cnt_a), 3);

    // Gating in IDLE.
    snap = deq_a;
    doc_avail = 1'b0;
    q_empty = 1'b0;
    repeat (20) tick();
    chk("gate_doc", deq_a - snap, 0);
    doc_avail = 1'b1;
    q_empty = 1'b1;
    repeat (20) tick();
    chk("gate_empty", deq_a - snap, 0);

    // doc_avail dropped mid-treatment.
    fifo.push_back(4'b0110);
    q_empty = 1'b0;
    wait_req("drop", gap);
    run_patient("drop", 1, 2, 4, 1'b1);
    chk("drop_cnt", int'(cnt_a), 4);

    // Asynchronous reset during TREAT.
    fifo.push_back(4'b1111);
    doc_avail = 1'b1;
    wait_req("ar", gap);
    doc_avail = 1'b0;
    repeat (4) tick();
    chk("ar_busy_pre", int'(busy_a), 1);
    snap = done_a_n;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", int'(busy_a), 0);
    chk("ar_pri", int'(pri_a), 0);
    chk("ar_id", int'(id_a), 0);
    chk("ar_cnt", int'(cnt_a), 0);
    repeat (10) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("ar_no_done", done_a_n - snap, 0);
    chk("ar_cnt_post", int'(cnt_a), 0);
    chk("ar_idle", int'(busy_a), 0);

    // Counter wrap on instance b, a held in reset.
    rst_n = 1'b0;
    fifo.delete();
    q_data = 4'b0000;
    q_empty = 1'b0;
    doc_avail = 1'b1;
    rst_b = 1'b1;
    snap = 0;
    while (done_b_n < 256 && snap < 3000) begin
      tick();
      snap++;
    end
    chk("wrap_done_n", done_b_n, 256);
    tick();
    chk("wrap_cnt", int'(cnt_b), 0);
    chk("wrap_deq_n", deq_b, 256);
    chk("wrap_busy", int'(busy_b), 0);
    chk("wrap_pri", int'(pri_b), 0);
    chk("wrap_id", int'(id_b), 0);

    chk("no_clash", clash, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
